// File: rtl/mel_log_compress.sv
// Log-compression stage after the mel filterbank: captures a frame of mel energies,
// then streams Mitchell-approximated log2 values over a valid/ready handshake.
module mel_log_compress #(
    parameter int IN_WIDTH    = 24,
    parameter int NUM_FILTERS = 26,
    parameter int FRAC_BITS   = 4,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_FILTERS*IN_WIDTH-1:0]  mel_in,
    input  logic                             mel_valid,
    output logic                             busy,
    output logic [OUT_WIDTH-1:0]             log_data,
    output logic                             log_valid,
    input  logic                             log_ready,
    output logic [$clog2(NUM_FILTERS)-1:0]   log_index,
    output logic                             log_last,
    output logic [7:0]                       drop_count
);

    localparam int IDX_W = $clog2(NUM_FILTERS);
    localparam int PW    = $clog2(IN_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                     state_q;
    logic signed [IN_WIDTH-1:0] buf_q [NUM_FILTERS];
    logic [OUT_WIDTH-1:0]       log_data_q;
    logic                       log_valid_q;
    logic [IDX_W-1:0]           log_index_q;
    logic                       log_last_q;
    logic                       busy_q;
    logic [7:0]                 drop_q;

    logic                       handshake_s;
    logic                       at_last_s;
    logic                       capture_s;
    logic                       drop_s;
    logic [IDX_W-1:0]           sel_d;
    logic [OUT_WIDTH-1:0]       log_d;

    // Mitchell log2: integer part is the MSB position, fraction is the bits just below it.
    function automatic logic [OUT_WIDTH-1:0] log2_fn(input logic signed [IN_WIDTH-1:0] x);
        logic [IN_WIDTH-1:0]  mag;
        logic [IN_WIDTH-1:0]  norm;
        logic [PW-1:0]        p;
        logic [FRAC_BITS-1:0] f;
        logic [OUT_WIDTH-1:0] res;
        mag = x;
        p   = '0;
        for (int b = 0; b < IN_WIDTH - 1; b++) begin
            if (mag[b]) begin
                p = PW'(b);
            end else begin
                p = p;
            end
        end
        norm = mag << (PW'(IN_WIDTH - 1) - p);
        f    = norm[IN_WIDTH-2 -: FRAC_BITS];
        res  = '0;
        if (!x[IN_WIDTH-1] && (x != '0)) begin
            res[PW+FRAC_BITS-1:0] = {p, f};
        end else begin
            res = '0;
        end
        return res;
    endfunction

    // Handshake decode, next element selection and drop/accept decisions.
    always_comb begin
        handshake_s = log_valid_q && log_ready;
        at_last_s   = (log_index_q == LAST_IDX);
        if ((state_q == EMIT) && !at_last_s) begin
            sel_d = log_index_q + IDX_W'(1);
        end else begin
            sel_d = '0;
        end
        log_d = log2_fn(buf_q[sel_d]);
        case (state_q)
            IDLE: begin
                capture_s = mel_valid;
                drop_s    = 1'b0;
            end
            LOAD: begin
                capture_s = 1'b0;
                drop_s    = mel_valid;
            end
            EMIT: begin
                capture_s = mel_valid && handshake_s && at_last_s;
                drop_s    = mel_valid && !(handshake_s && at_last_s);
            end
            default: begin
                capture_s = 1'b0;
                drop_s    = 1'b0;
            end
        endcase
    end

    // Frame buffer; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture_s && !rst) begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                buf_q[i] <= mel_in[i*IN_WIDTH +: IN_WIDTH];
            end
        end else begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                buf_q[i] <= buf_q[i];
            end
        end
    end

    // Control FSM with registered stream outputs and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            log_data_q  <= '0;
            log_valid_q <= 1'b0;
            log_index_q <= '0;
            log_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 8'd0;
        end else begin
            if (drop_s && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (mel_valid) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    log_data_q  <= log_d;
                    log_index_q <= '0;
                    log_last_q  <= (LAST_IDX == '0);
                    log_valid_q <= 1'b1;
                    state_q     <= EMIT;
                end
                EMIT: begin
                    if (handshake_s && at_last_s) begin
                        log_valid_q <= 1'b0;
                        log_last_q  <= 1'b0;
                        if (mel_valid) begin
                            state_q <= LOAD;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (handshake_s) begin
                        log_data_q  <= log_d;
                        log_index_q <= sel_d;
                        log_last_q  <= (sel_d == LAST_IDX);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    log_valid_q <= 1'b0;
                    log_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign log_data   = log_data_q;
    assign log_valid  = log_valid_q;
    assign log_index  = log_index_q;
    assign log_last   = log_last_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_mel_log_compress.sv
// Randomized self-checking bench for mel_log_compress against an arithmetic log2 model.
module tb_mel_log_compress;

    localparam int NF = 26;
    localparam int IW = 24;

    logic              clk;
    logic              rst;
    logic [NF*IW-1:0]  mel_in;
    logic              mel_valid;
    logic              busy;
    logic [15:0]       log_data;
    logic              log_valid;
    logic              log_ready;
    logic [4:0]        log_index;
    logic              log_last;
    logic [7:0]        drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    int          frame_v [NF];
    int          exp_v   [NF];
    logic [15:0] obs_data [NF];
    logic [4:0]  obs_idx  [NF];
    logic        obs_last [NF];

    mel_log_compress dut (
        .clk        (clk),
        .rst        (rst),
        .mel_in     (mel_in),
        .mel_valid  (mel_valid),
        .busy       (busy),
        .log_data   (log_data),
        .log_valid  (log_valid),
        .log_ready  (log_ready),
        .log_index  (log_index),
        .log_last   (log_last),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: floor(log2 x) as integer part, next four bits below the MSB as fraction.
    function automatic int ref_log(input int x);
        int p;
        int f;
        if (x <= 0) return 0;
        p = 0;
        while ((x >> (p + 1)) != 0) p++;
        if (p >= 4) f = (x >> (p - 4)) & 15;
        else        f = (x << (4 - p)) & 15;
        return p * 16 + f;
    endfunction

    function automatic int rand_val();
        int r;
        r = int'($urandom_range(0, 32'h007FFFFF)) >> $urandom_range(0, 22);
        case ($urandom_range(0, 9))
            0:       r = -r;
            1:       r = 0;
            default: r = r;
        endcase
        return r;
    endfunction

    task automatic load_frame();
        for (int i = 0; i < NF; i++) begin
            mel_in[i*IW +: IW] = frame_v[i][IW-1:0];
            exp_v[i] = ref_log(frame_v[i]);
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < NF; i++) frame_v[i] = rand_val();
        load_frame();
    endtask

    task automatic start_frame();
        @(negedge clk);
        mel_valid = 1'b1;
    endtask

    // Drains one frame under a ready pattern, recording accepted beats and stall instability.
    task automatic collect(input int mode, output int got, output int unstable);
        int          cyc;
        logic        r;
        logic        pv_stall;
        logic [15:0] pd;
        logic [4:0]  pi;
        logic        pl;
        got = 0; unstable = 0; cyc = 0; pv_stall = 1'b0;
        pd = '0; pi = '0; pl = 1'b0;
        while (got < NF && cyc < 2000) begin
            @(negedge clk);
            mel_valid = 1'b0;
            if (pv_stall && !log_valid) unstable++;
            if (pv_stall && log_valid && (log_data !== pd || log_index !== pi || log_last !== pl))
                unstable++;
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            log_ready = r;
            if (log_valid && r) begin
                obs_data[got] = log_data;
                obs_idx[got]  = log_index;
                obs_last[got] = log_last;
                got++;
            end
            pv_stall = log_valid && !r;
            pd = log_data; pi = log_index; pl = log_last;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mel_valid = 1'b1;
        log_ready = 1'b0;
        mel_in = {NF{24'h123456}};
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, log_valid, log_last, log_data, log_index, drop_count} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b valid=%0b last=%0b data=%0h idx=%0d drop=%0d want all 0",
                     busy, log_valid, log_last, log_data, log_index, drop_count);
        end
        rst = 1'b0;
        mel_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || log_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_capture: got busy=%0b valid=%0b want 0 0", busy, log_valid);
        end
    endtask

    task automatic test_ramp();
        int e;
        for (int i = 0; i < NF; i++) frame_v[i] = (i <= 22) ? (1 << i) : 0;
        frame_v[25] = -5;
        load_frame();
        @(negedge clk);
        mel_valid = 1'b1;
        log_ready = 1'b1;
        @(negedge clk);
        mel_valid = 1'b0;
        n_checks++;
        if (log_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_latency1: got valid=%0b busy=%0b want 0 1", log_valid, busy);
        end
        @(negedge clk);
        for (int i = 0; i < NF; i++) begin
            e = (i <= 22) ? i * 16 : 0;
            n_checks++;
            if (log_valid !== 1'b1 || log_index !== 5'(i) || log_data !== 16'(e) || log_last !== (i == 25)) begin
                n_fail++;
                $display("FAIL ramp_beat[%0d]: got valid=%0b idx=%0d data=%0h last=%0b want 1 %0d %0h %0b",
                         i, log_valid, log_index, log_data, log_last, i, e, (i == 25));
            end
            @(negedge clk);
        end
        n_checks++;
        if (log_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_end: got valid=%0b busy=%0b want 0 0", log_valid, busy);
        end
    endtask

    task automatic test_fraction();
        int lit [10];
        int got;
        int unst;
        lit = '{32'h88, 32'h18, 32'h16F, 32'h24, 0, 32'h10, 0, 0, 0, 32'h160};
        random_frame();
        frame_v[0] = 384;       frame_v[1] = 3;  frame_v[2] = 32'h7FFFFF; frame_v[3] = 5;
        frame_v[4] = 1;         frame_v[5] = 2;  frame_v[6] = 0;          frame_v[7] = -1;
        frame_v[8] = -8388608;  frame_v[9] = 32'h400000;
        load_frame();
        start_frame();
        collect(0, got, unst);
        n_checks++;
        if (got !== NF) begin
            n_fail++;
            $display("FAIL frac_count: got %0d beats want %0d", got, NF);
        end
        for (int i = 0; i < NF; i++) begin
            n_checks++;
            if (obs_data[i] !== 16'((i < 10) ? lit[i] : exp_v[i])) begin
                n_fail++;
                $display("FAIL frac_data[%0d]: x=%0d got %0h want %0h", i, frame_v[i], obs_data[i],
                         (i < 10) ? lit[i] : exp_v[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int got;
        int unst;
        for (int f = 0; f < 4; f++) begin
            random_frame();
            start_frame();
            collect((f == 0) ? 1 : 2, got, unst);
            n_checks++;
            if (got !== NF || unst !== 0) begin
                n_fail++;
                $display("FAIL bp_stream[%0d]: got beats=%0d unstable=%0d want %0d 0", f, got, unst, NF);
            end
            for (int i = 0; i < NF; i++) begin
                n_checks++;
                if (obs_idx[i] !== 5'(i) || obs_data[i] !== 16'(exp_v[i]) || obs_last[i] !== (i == NF - 1)) begin
                    n_fail++;
                    $display("FAIL bp_beat[%0d.%0d]: got idx=%0d data=%0h last=%0b want %0d %0h %0b",
                             f, i, obs_idx[i], obs_data[i], obs_last[i], i, exp_v[i], (i == NF - 1));
                end
            end
        end
    endtask

    task automatic test_overlap();
        logic [NF*IW-1:0] pack_b;
        logic [NF*IW-1:0] pack_c;
        int               exp_c [NF];
        int               w;
        random_frame(); pack_c = mel_in; exp_c = exp_v;
        random_frame(); pack_b = mel_in;
        random_frame();
        log_ready = 1'b1;
        start_frame();
        @(negedge clk);
        mel_valid = 1'b0;
        w = 0;
        while (!log_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        for (int k = 0; k < NF; k++) begin
            n_checks++;
            if (log_valid !== 1'b1 || log_index !== 5'(k) || log_data !== 16'(exp_v[k])) begin
                n_fail++;
                $display("FAIL ovl_first[%0d]: got valid=%0b idx=%0d data=%0h want 1 %0d %0h",
                         k, log_valid, log_index, log_data, k, exp_v[k]);
            end
            if (k == 5) begin
                mel_in = pack_b; mel_valid = 1'b1;
            end else if (k == NF - 1) begin
                mel_in = pack_c; mel_valid = 1'b1;
            end else begin
                mel_valid = 1'b0;
            end
            @(negedge clk);
        end
        mel_valid = 1'b0;
        n_checks++;
        if (log_valid !== 1'b0 || busy !== 1'b1 || drop_count !== 8'd1) begin
            n_fail++;
            $display("FAIL ovl_accept: got valid=%0b busy=%0b drop=%0d want 0 1 1", log_valid, busy, drop_count);
        end
        @(negedge clk);
        for (int k = 0; k < NF; k++) begin
            n_checks++;
            if (log_valid !== 1'b1 || log_index !== 5'(k) || log_data !== 16'(exp_c[k])) begin
                n_fail++;
                $display("FAIL ovl_third[%0d]: got valid=%0b idx=%0d data=%0h want 1 %0d %0h",
                         k, log_valid, log_index, log_data, k, exp_c[k]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (drop_count !== 8'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovl_final: got drop=%0d busy=%0b want 1 0", drop_count, busy);
        end
    endtask

    task automatic test_drop_saturate();
        int got;
        int unst;
        random_frame();
        log_ready = 1'b0;
        start_frame();
        @(negedge clk);
        mel_valid = 1'b0;
        @(negedge clk);
        mel_valid = 1'b1;
        repeat (300) @(negedge clk);
        mel_valid = 1'b0;
        n_checks++;
        if (drop_count !== 8'd255 || log_valid !== 1'b1 || log_index !== 5'd0 || log_data !== 16'(exp_v[0])) begin
            n_fail++;
            $display("FAIL drop_sat: got drop=%0d valid=%0b idx=%0d data=%0h want 255 1 0 %0h",
                     drop_count, log_valid, log_index, log_data, exp_v[0]);
        end
        collect(0, got, unst);
        n_checks++;
        if (got !== NF || obs_data[NF-1] !== 16'(exp_v[NF-1]) || obs_idx[NF-1] !== 5'(NF - 1)) begin
            n_fail++;
            $display("FAIL drop_drain: got beats=%0d last_data=%0h want %0d %0h", got, obs_data[NF-1], NF, exp_v[NF-1]);
        end
    endtask

    task automatic test_midreset();
        int w;
        int got;
        int unst;
        random_frame();
        log_ready = 1'b1;
        start_frame();
        @(negedge clk);
        mel_valid = 1'b0;
        w = 0;
        while (!(log_valid && log_index == 5'd10) && w < 40) begin
            @(negedge clk);
            w++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (log_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd0 || log_data !== 16'd0 || log_last !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: got valid=%0b busy=%0b drop=%0d data=%0h last=%0b want all 0",
                     log_valid, busy, drop_count, log_data, log_last);
        end
        random_frame();
        start_frame();
        collect(0, got, unst);
        n_checks++;
        if (got !== NF) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d beats want %0d", got, NF);
        end
        for (int i = 0; i < NF; i++) begin
            n_checks++;
            if (obs_idx[i] !== 5'(i) || obs_data[i] !== 16'(exp_v[i])) begin
                n_fail++;
                $display("FAIL midrst_beat[%0d]: got idx=%0d data=%0h want %0d %0h",
                         i, obs_idx[i], obs_data[i], i, exp_v[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        mel_valid = 1'b0;
        log_ready = 1'b0;
        mel_in = '0;
        test_reset();
        test_ramp();
        test_fraction();
        test_backpressure();
        test_overlap();
        test_drop_saturate();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
